// File: rtl/run_limit_stuff_tx.sv
// rtl/run_limit_stuff_tx.sv - serializer that stuffs a complement bit after any two equal bits
// Words go out LSB first; the line never carries three equal bits while tx_valid stays high.
module run_limit_stuff_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_stuff,
  output logic              busy
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        run_q;
  logic [1:0]        run_d;
  logic              last_q;
  logic              armed_q;
  logic              cur_bit;
  logic              last_data;
  logic              accept;
  logic              more_data;

  // A stuff bit is always the complement of what was just sent, so it never extends a run.
  assign cur_bit   = (state_q == STUFF) ? ~last_q : shreg_q[cnt_q];
  assign last_data = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign in_ready  = ((state_q == IDLE) && armed_q) || last_data;
  assign accept    = in_valid && in_ready;
  assign more_data = (cnt_q != LAST_IDX) || accept;
  assign run_d     = ((cur_bit == last_q) && (run_q != 2'd0)) ? run_q + 2'd1 : 2'd1;

  assign tx_valid  = (state_q != IDLE);
  assign tx_stuff  = (state_q == STUFF);
  assign tx_bit    = tx_valid ? cur_bit : 1'b0;
  assign busy      = tx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      run_q   <= 2'd0;
      last_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        shreg_q <= in_data;
        cnt_q   <= '0;
      end
      unique case (state_q)
        IDLE: begin
          run_q <= 2'd0;
          if (accept) state_q <= SHIFT;
        end
        SHIFT: begin
          run_q  <= run_d;
          last_q <= cur_bit;
          if (cnt_q != LAST_IDX) cnt_q <= cnt_q + CW'(1);
          // Stuff only when a data bit follows; a frame never ends on a stuff bit.
          if (!more_data) state_q <= IDLE;
          else if (run_d == 2'd2) state_q <= STUFF;
          else state_q <= SHIFT;
        end
        STUFF: begin
          run_q   <= run_d;
          last_q  <= cur_bit;
          state_q <= SHIFT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/run_limit_stuff_tx.md
RUN_LIMIT_STUFF_TX -- requirements
Module: run_limit_stuff_tx

Interface
REQ-001 Parameter: DATA_W, 8, width of the parallel input word; legal values 2..32.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  DATA_W  parallel word to transmit, LSB first.
REQ-005 in_valid  input  1  source has a word on in_data.
REQ-006 in_ready  output  1  block accepts in_data on this cycle.
REQ-007 tx_bit  output  1  serial line bit.
REQ-008 tx_valid  output  1  tx_bit is meaningful this cycle.
REQ-009 tx_stuff  output  1  current tx_bit is an inserted stuff bit, not data.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 Purpose: the serial stream SHALL never contain three equal consecutive bits (no 000 or 111) while tx_valid is continuously high.
REQ-012 States SHALL be IDLE, SHIFT and STUFF; all outputs, including in_ready, SHALL be decoded from registered state only, with no input-to-output combinational path.
REQ-013 Handshake: a word SHALL transfer on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be ignored on all other cycles.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in SHIFT while the last data bit (bit DATA_W-1) is on tx_bit, and 0 otherwise, including in STUFF.
REQ-015 Latency: the first bit of an accepted word SHALL appear on tx_bit in the cycle after the accepting edge.
REQ-016 SHIFT: tx_valid=1, tx_stuff=0, tx_bit = next unsent data bit, LSB first.
REQ-017 STUFF: tx_valid=1, tx_stuff=1, tx_bit = complement of the previously emitted bit; no data bit is consumed.
REQ-018 IDLE: tx_valid=0, tx_stuff=0, tx_bit=0.
REQ-019 Run tracking: the block SHALL hold last_bit and run_len (0..2); every emitted bit b, data or stuff, SHALL set run_len to run_len+1 if b equals last_bit and run_len>0, and to 1 otherwise, and SHALL set last_bit to b.
REQ-020 After an emitted bit, if the updated run_len=2 and another data bit follows (remaining bits of the current word, or a word accepted on that edge), the next state SHALL be STUFF; otherwise it SHALL be SHIFT, or IDLE if no data remains.
REQ-021 After STUFF, the next state SHALL be SHIFT; STUFF is never followed by STUFF.
REQ-022 Back-to-back: a word accepted while the last data bit is on tx_bit SHALL continue the stream with no gap, and the run history SHALL carry across the word boundary.
REQ-023 End of stream: with no new word, the block SHALL enter IDLE after the last data bit; no trailing stuff bit SHALL be sent.
REQ-024 Any cycle spent in IDLE SHALL clear run_len to 0, so a new frame starts with no history.
REQ-025 A bit counter SHALL track data bits 0..DATA_W-1 and wrap to 0 on word load; stuff cycles SHALL NOT advance it.

Reset
REQ-026 While rst=0, the block SHALL be in IDLE with in_ready=0, tx_valid=0, tx_bit=0, tx_stuff=0, busy=0, run_len=0, last_bit=0, bit counter=0 and the shift register cleared.
REQ-027 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-028 Reset asserted mid-word SHALL abort the word immediately; no remnant bits SHALL be sent after release.

Verification
REQ-029 Single 0x00 (DATA_W=8) -> tx_bit 0 0 1 0 0 1 0 0 1 0 0 over 11 cycles; tx_stuff=1 at cycles 3, 6 and 9; then IDLE.
REQ-030 Single 0xFF -> 1 1 0 1 1 0 1 1 0 1 1, with stuffs at cycles 3, 6 and 9; single 0x55 -> 1 0 1 0 1 0 1 0 over 8 cycles with no stuff.
REQ-031 Two 0x00 words, in_valid held high -> second word accepted on cycle 11; cycle 12 is a stuff 1; 23 continuous tx_valid cycles with 7 stuffs; no 000 or 111 anywhere.
REQ-032 0xFF, then one IDLE cycle, then 0xFF -> the second word begins 1 1 with no leading stuff, confirming history is cleared.
REQ-033 rst pulsed low at cycle 4 of a 0x00 word -> outputs go to reset values asynchronously; after release the next word 0x55 is sent as exactly 1 0 1 0 1 0 1 0.
REQ-034 Random words with random in_valid gaps (10k words) -> a scoreboard confirms de-stuffed data equals the input words, no 000/111 within any continuous tx_valid run, and in_ready never high in STUFF.
